// File: rtl/noc_multi_display_pio.sv
// noc_multi_display_pio: multi-channel seven-segment display PIO on the NOC
// Avalon-MM peripheral bus, with optional hex decode, hardware blink, global
// output polarity and a synchronised edge-capturing input port with interrupt.
module noc_multi_display_pio #(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = 7,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [IN_W-1:0]       in_port,
    output logic [NUM_CH*7-1:0]   out_port,
    output logic                  irq
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    localparam logic [3:0] ADDR_CTRL    = 4'd8;
    localparam logic [3:0] ADDR_IN_DATA = 4'd9;
    localparam logic [3:0] ADDR_EDGE    = 4'd10;
    localparam logic [3:0] ADDR_MASK    = 4'd11;

    // Hex digit to active-high segment pattern, bit 0 = a ... bit 6 = g
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic                     wr_en;
    logic [NUM_CH-1:0][6:0]   data_q, data_d;
    logic [NUM_CH-1:0]        decode_en_q, decode_en_d;
    logic [NUM_CH-1:0]        blink_en_q, blink_en_d;
    logic                     invert_q, invert_d;
    logic [IN_W-1:0]          s1_q, s2_q, d_q;
    logic [IN_W-1:0]          edge_q, edge_d;
    logic [IN_W-1:0]          irq_mask_q, irq_mask_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     phase_q, phase_d;
    logic [NUM_CH*7-1:0]      out_q, out_d;
    logic [31:0]              readdata_q, readdata_d;
    logic                     unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Register-file writes; CTRL bits for absent channels are simply dropped
    always_comb begin
        data_d      = data_q;
        decode_en_d = decode_en_q;
        blink_en_d  = blink_en_q;
        invert_d    = invert_q;
        irq_mask_d  = irq_mask_q;
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr_en && address == 4'(n)) begin
                data_d[n] = writedata[6:0];
            end
        end
        if (wr_en && address == ADDR_CTRL) begin
            decode_en_d = writedata[NUM_CH-1:0];
            blink_en_d  = writedata[8 +: NUM_CH];
            invert_d    = writedata[16];
        end
        if (wr_en && address == ADDR_MASK) begin
            irq_mask_d = writedata[IN_W-1:0];
        end
    end

    // Sticky rising-edge capture; a new edge beats a same-cycle clear
    always_comb begin
        edge_d = edge_q;
        if (wr_en && address == ADDR_EDGE) begin
            edge_d = edge_q & ~writedata[IN_W-1:0];
        end
        edge_d = edge_d | (s2_q & ~d_q);
    end

    // Free-running blink divider; phase flips each time the counter wraps
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Segment pipeline: decode or raw, then blink blanking, then polarity
    always_comb begin
        logic [6:0] seg;
        seg   = '0;
        out_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            seg = decode_en_q[n] ? hex7(data_q[n][3:0]) : data_q[n];
            if (blink_en_q[n] && phase_q) begin
                seg = '0;
            end
            out_d[7*n +: 7] = seg ^ {7{invert_q}};
        end
    end

    // Read mux, sampled every clock regardless of chipselect
    always_comb begin
        readdata_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (address == 4'(n)) begin
                readdata_d[6:0] = data_q[n];
            end
        end
        case (address)
            ADDR_CTRL: begin
                readdata_d[NUM_CH-1:0]  = decode_en_q;
                readdata_d[8 +: NUM_CH] = blink_en_q;
                readdata_d[16]          = invert_q;
            end
            ADDR_IN_DATA: readdata_d[IN_W-1:0] = s2_q;
            ADDR_EDGE:    readdata_d[IN_W-1:0] = edge_q;
            ADDR_MASK:    readdata_d[IN_W-1:0] = irq_mask_q;
            default:      ;
        endcase
    end

    // All state registers, cleared asynchronously by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            decode_en_q <= '0;
            blink_en_q  <= '0;
            invert_q    <= 1'b0;
            irq_mask_q  <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            d_q         <= '0;
            edge_q      <= '0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            out_q       <= '0;
            readdata_q  <= '0;
        end else begin
            data_q      <= data_d;
            decode_en_q <= decode_en_d;
            blink_en_q  <= blink_en_d;
            invert_q    <= invert_d;
            irq_mask_q  <= irq_mask_d;
            s1_q        <= in_port;
            s2_q        <= s1_q;
            d_q         <= s2_q;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
            readdata_q  <= readdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = readdata_q;
    assign irq      = |(edge_q & irq_mask_q);

endmodule

// File: tb/tb_noc_multi_display_pio.sv
// Directed testbench for noc_multi_display_pio (NUM_CH=4, IN_W=7, BLINK_DIV=4)
module tb_noc_multi_display_pio;

    localparam int NUM_CH    = 4;
    localparam int IN_W      = 7;
    localparam int BLINK_DIV = 4;

    logic                  clk;
    logic                  reset_n;
    logic [3:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [IN_W-1:0]       in_port;
    logic [NUM_CH*7-1:0]   out_port;
    logic                  irq;

    int checks = 0;
    int errors = 0;

    noc_multi_display_pio #(
        .NUM_CH    (NUM_CH),
        .IN_W      (IN_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus write, performed at the next rising edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Present an address for one edge, then compare the registered read data
    task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        address = a;
        tick();
        check_output(tag, readdata, exp);
    endtask

    function automatic logic [6:0] ch(input int n);
        return out_port[7*n +: 7];
    endfunction

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // Reset state
        #12;
        check_output("reset_out_port", 32'(out_port), 32'h0);
        check_output("reset_readdata", readdata, 32'h0);
        check_output("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Raw data write and output latency
        bus_write(4'd2, 32'h55);
        check_output("data2_not_yet", 32'(ch(2)), 32'h00);
        tick();
        check_output("data2_out", 32'(ch(2)), 32'h55);
        bus_read("read_data2", 4'd2, 32'h55);

        // Hex decode and inversion
        bus_write(4'd8, 32'h0000_000F);
        bus_write(4'd0, 32'h0A);
        bus_write(4'd1, 32'h0F);
        tick();
        check_output("dec_ch0_A", 32'(ch(0)), 32'h77);
        check_output("dec_ch1_F", 32'(ch(1)), 32'h71);
        check_output("dec_ch2_hi_ignored", 32'(ch(2)), 32'h6D);
        bus_write(4'd8, 32'h0001_000F);
        tick();
        check_output("inv_ch0", 32'(ch(0)), 32'h08);
        check_output("inv_ch1", 32'(ch(1)), 32'h0E);
        check_output("inv_ch2", 32'(ch(2)), 32'h12);
        check_output("inv_ch3", 32'(ch(3)), 32'h40);
        bus_read("read_ctrl", 4'd8, 32'h0001_000F);

        // Unmapped addresses and CTRL bits for absent channels
        bus_write(4'd8, 32'h0000_F0F0);
        bus_read("ctrl_absent_bits", 4'd8, 32'h0);
        bus_write(4'd12, 32'hFFFF_FFFF);
        bus_read("read_addr12", 4'd12, 32'h0);
        bus_write(4'd7, 32'h7F);
        bus_read("read_addr7", 4'd7, 32'h0);
        bus_read("data2_unchanged", 4'd2, 32'h55);
        bus_read("mask_unchanged", 4'd11, 32'h0);
        check_output("out_raw_all", 32'(out_port), 32'({7'h00, 7'h55, 7'h0F, 7'h0A}));

        // Masked rising edge on bit 0
        bus_write(4'd11, 32'h1);
        bus_read("read_mask", 4'd11, 32'h1);
        in_port[0] = 1'b1;
        tick();
        check_output("irq_edge1", 32'(irq), 32'h0);
        tick();
        check_output("irq_edge2", 32'(irq), 32'h0);
        tick();
        check_output("irq_edge3", 32'(irq), 32'h1);
        bus_read("edge_set", 4'd10, 32'h1);
        bus_read("in_data_high", 4'd9, 32'h1);
        in_port[0] = 1'b0;
        repeat (4) tick();
        bus_read("edge_after_fall", 4'd10, 32'h1);
        check_output("irq_held", 32'(irq), 32'h1);
        bus_read("in_data_low", 4'd9, 32'h0);
        bus_write(4'd10, 32'h1);
        check_output("irq_cleared", 32'(irq), 32'h0);
        bus_read("edge_cleared", 4'd10, 32'h0);

        // Unmasked bit captures but does not interrupt
        in_port[2] = 1'b1;
        repeat (4) tick();
        check_output("irq_unmasked", 32'(irq), 32'h0);
        bus_read("edge_bit2", 4'd10, 32'h4);
        in_port[2] = 1'b0;
        bus_write(4'd10, 32'h4);
        repeat (3) tick();
        bus_read("edge_bit2_clr", 4'd10, 32'h0);

        // Rising edge and write-1-clear in the same cycle: set wins
        in_port[0] = 1'b1;
        tick();
        tick();
        bus_write(4'd10, 32'h1);
        check_output("set_wins_irq", 32'(irq), 32'h1);
        bus_read("set_wins_edge", 4'd10, 32'h1);

        // Asynchronous reset mid-operation
        in_port = '0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_output("midreset_irq", 32'(irq), 32'h0);
        check_output("midreset_out", 32'(out_port), 32'h0);
        check_output("midreset_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Blink with divider 4, counting edges from reset release
        bus_write(4'd3, 32'h7F);     // edge 1
        bus_write(4'd8, 32'h0800);   // edge 2
        bus_write(4'd0, 32'h12);     // edge 3
        for (int k = 4; k < 20; k++) begin
            tick();
            check_output($sformatf("blink_ch3_e%0d", k), 32'(ch(3)),
                         ((((k - 1) / 4) % 2) == 1) ? 32'h00 : 32'h7F);
            check_output($sformatf("steady_ch0_e%0d", k), 32'(ch(0)), 32'h12);
        end
        check_output("steady_ch1", 32'(ch(1)), 32'h00);
        bus_read("no_edge_after_reset", 4'd10, 32'h0);
        check_output("irq_after_reset", 32'(irq), 32'h0);
        bus_read("data2_reset", 4'd2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
